fft_bitrev_reorder: RTL and testbench
=====================================

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 Parameter N, default 1024: FFT frame length, power of 2.
REQ-002 Parameter N_LOG2, default 10: log2(N), the index width.
REQ-003 Parameter DW, default 25: sample width, signed, equal to the FFT OUTPUT_WIDTH.
REQ-004 clk_i  input  1: single clock; all logic on posedge.
REQ-005 rst_i  input  1: reset, asynchronous, active-high.
REQ-006 sync_i  input  1: upstream FFT output-valid; high for every valid input sample.
REQ-007 ctr_i  input  N_LOG2: frequency-bin index of the current input sample, arriving in bit-reversed sequence.
REQ-008 data_re_i / data_im_i  input  DW signed each: input sample.
REQ-009 valid_o  output  1: the output sample is valid.
REQ-010 ready_i  input  1: the downstream consumer accepts the output sample.
REQ-011 ctr_o  output  N_LOG2: natural-order bin index of the output sample.
REQ-012 data_re_o / data_im_o  output  DW signed each: output sample.
REQ-013 last_o  output  1: high with bin N-1 of each output frame.
REQ-014 overrun_o  output  1: single-cycle pulse when an input frame is dropped.
REQ-015 abort_o  output  1: single-cycle pulse when a partial input frame is discarded.

Function
REQ-016 Buffer: two banks (0,1), each N x 2·DW, write-addressed by ctr_i and read-addressed by the natural index.
REQ-017 Bank states: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
REQ-018 Writer frame start: a frame starts on a sync_i=1 cycle while wr_cnt=0.
  - If an EMPTY bank exists, the writer claims it (FILLING); bank 0 has priority when both are EMPTY.
  - Otherwise the writer counts N samples without writing, and overrun_o pulses on the start cycle.
REQ-019 Writer write: each sync_i=1 cycle writes {re,im} at address ctr_i and increments wr_cnt modulo N; the wr_cnt=N-1 write marks the bank FULL next cycle.
REQ-020 Writer abort: if sync_i falls with wr_cnt≠0, the FILLING bank returns to EMPTY, wr_cnt returns to 0, and abort_o pulses once; a dropped (overrun) frame aborts silently.
REQ-021 Reader order: the reader serves FULL banks in completion order (READING) and issues read addresses 0..N-1.
REQ-022 Reader advance: the read address advances only when the output pipeline has room, i.e. the output register is empty or ready_i=1.
REQ-023 Bank release: a bank becomes EMPTY the cycle after its address N-1 is issued, and the writer may claim it in that same cycle.
REQ-024 Output pipeline: 1-cycle RAM read plus an output register.
  - First valid_o occurs 2 cycles after a bank becomes FULL when the reader is idle and ready_i=1.
REQ-025 Output hold: while valid_o=1 and ready_i=0, ctr_o, data_re_o, data_im_o and last_o hold stable.
  - Under any ready_i pattern, no sample is lost, duplicated or reordered.
REQ-026 Sustained rate: with continuous sync_i and ready_i=1, throughput is 1 sample/cycle with no overrun indefinitely.
REQ-027 Back-to-back frames: the reader starts the next FULL bank immediately after the previous bank's N-1 issue, with no bubble.
REQ-028 Unused input: ctr_i is ignored when sync_i=0.
REQ-029 Duplicates: a duplicate ctr_i within one frame overwrites the earlier sample (no detection).
REQ-030 Arithmetic: data passes bit-exact; there is no arithmetic or width change.

Reset
REQ-031 Reset values, while rst_i=1:
  - Both banks EMPTY; wr_cnt=0; the read counter is 0.
  - valid_o=0, last_o=0, overrun_o=0, abort_o=0.
  - ctr_o=0, data_re_o=0, data_im_o=0.
REQ-032 Mid-operation reset: rst_i asserted mid-frame discards all buffered and partial frames with no abort_o pulse.
  - The first sync_i=1 after release starts a new frame.
REQ-033 RAM contents are not reset; correctness never depends on them.

Structure
REQ-034 The bank-state encoding (EMPTY=2'd0, FILLING=2'd1, FULL=2'd2, READING=2'd3) lives in the shared FFT package/header, alongside the N and N_LOG2 defaults.
REQ-035 One sub-module, fft_reorder_ram: a simple dual-port RAM (one write port, one registered read port), parameterized by depth and width, instantiated once per bank.

Verification (bench: N=16, N_LOG2=4, DW=8)
REQ-036 Single frame: sync_i high for 16 cycles, ctr_i in bit-reversed order 0,8,4,12,..., data_re=ctr_i, data_im=-ctr_i, ready_i=1.
  - Output ctr_o=0..15 with data_re_o=ctr_o; first valid_o 2 cycles after the last input; last_o at ctr_o=15.
REQ-037 Continuous 5 frames with ready_i=1: 80 consecutive valid_o cycles, no gaps after the first, and overrun_o never pulses.
REQ-038 Backpressure: ready_i=0 for 20 cycles starting mid-frame 2.
  - Output holds stable; frame 3 input is dropped with one overrun_o pulse.
  - Frames 1-2 output complete, in order.
REQ-039 Partial frame: sync_i drops after 7 samples.
  - One abort_o pulse, no output produced.
  - The next full frame outputs correctly from the same bank.
REQ-040 Reset mid-frame: rst_i pulsed during frame-1 input and during frame-0 output.
  - valid_o falls asynchronously to 0; no stale data appears afterwards.
  - The next frame outputs correctly.

Source files
------------

// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared definitions for the FFT output reorder path: frame-size defaults,
// ping-pong bank state encoding and a small bank-selection helper.
package fft_bitrev_reorder_pkg;

    localparam int FFT_N      = 1024;
    localparam int FFT_N_LOG2 = 10;
    localparam int FFT_DW     = 25;

    // Lifecycle of one reorder bank; values are fixed because other FFT
    // blocks decode them.
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;

    // Choose the FULL bank to drain next. When both are FULL the one that
    // completed first (oldest) wins. Returns {found, bank}.
    function automatic logic [1:0] pick_full_bank(
        input bank_state_t st0,
        input bank_state_t st1,
        input logic        oldest
    );
        logic old_full;
        logic new_full;
        old_full = ((oldest ? st1 : st0) == BANK_FULL);
        new_full = ((oldest ? st0 : st1) == BANK_FULL);
        if (old_full) begin
            return {1'b1, oldest};
        end else if (new_full) begin
            return {1'b1, ~oldest};
        end else begin
            return {1'b0, oldest};
        end
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: one synchronous write port and one registered,
// enable-gated read port. The read register holds its value while re_i is
// low, which lets the reorder pipeline stall without re-reading.
module fft_reorder_ram
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int DEPTH = FFT_N,
    parameter int AW    = FFT_N_LOG2,
    parameter int WIDTH = 2 * FFT_DW
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Storage array write; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_r[waddr_i] <= wdata_i;
        end
    end

    // Registered read, updated only when a read is issued.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_r <= mem_r[raddr_i];
        end
    end

    assign rdata_o = rdata_r;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Converts the bit-reversed output stream of the FFT into natural bin order.
// Two ping-pong banks: the writer fills one bank at the incoming (reversed)
// bin index while the reader drains a completed bank sequentially through a
// RAM-read stage and a ready/valid output register.
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int N      = FFT_N,
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int DW     = FFT_DW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sync_i,
    input  logic [N_LOG2-1:0]    ctr_i,
    input  logic signed [DW-1:0] data_re_i,
    input  logic signed [DW-1:0] data_im_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [N_LOG2-1:0]    ctr_o,
    output logic signed [DW-1:0] data_re_o,
    output logic signed [DW-1:0] data_im_o,
    output logic                 last_o,
    output logic                 overrun_o,
    output logic                 abort_o
);

    // N is a power of two, so the last index is all ones and counters wrap
    // naturally at N.
    localparam logic [N_LOG2-1:0] CNT_ZERO = {N_LOG2{1'b0}};
    localparam logic [N_LOG2-1:0] CNT_ONE  = {{(N_LOG2-1){1'b0}}, 1'b1};
    localparam logic [N_LOG2-1:0] CNT_LAST = {N_LOG2{1'b1}};

    // Bank bookkeeping
    bank_state_t       bank_st_r  [2];
    bank_state_t       bank_nxt_s [2];
    logic              oldest_r;
    logic              oldest_nxt_s;

    // Writer
    logic [N_LOG2-1:0] wr_cnt_r;
    logic [N_LOG2-1:0] wr_cnt_nxt_s;
    logic              wr_bank_r;
    logic              wr_bank_nxt_s;
    logic              wr_drop_r;
    logic              wr_drop_nxt_s;
    logic              wr_other_s;
    logic              claim_s;
    logic              mark_full_s;
    logic              release_fill_s;
    logic              overrun_s;
    logic              abort_s;
    logic [1:0]        we_s;
    logic [2*DW-1:0]   wdata_s;

    // Reader
    logic [1:0]        pick_s;
    logic              full_found_s;
    logic              full_sel_s;
    logic              rd_active_r;
    logic              rd_bank_r;
    logic [N_LOG2-1:0] rd_addr_r;
    logic              cur_bank_s;
    logic              room_s;
    logic              issue_s;
    logic              rd_start_s;
    logic              rd_done_s;
    logic [1:0]        re_s;
    logic [2*DW-1:0]   rdata_s [2];

    // RAM-read stage and output register
    logic              s1_vld_r;
    logic              s1_bank_r;
    logic [N_LOG2-1:0] s1_addr_r;
    logic [2*DW-1:0]   s1_data_s;
    logic              valid_o_r;
    logic [N_LOG2-1:0] ctr_o_r;
    logic [DW-1:0]     data_re_o_r;
    logic [DW-1:0]     data_im_o_r;
    logic              last_o_r;
    logic              overrun_o_r;
    logic              abort_o_r;

    assign wdata_s    = {data_re_i, data_im_i};
    assign wr_other_s = ~wr_bank_r;

    // Writer decisions: frame start / bank claim or drop, per-sample write,
    // completion and abort of a partial frame.
    always_comb begin
        wr_cnt_nxt_s   = wr_cnt_r;
        wr_bank_nxt_s  = wr_bank_r;
        wr_drop_nxt_s  = wr_drop_r;
        claim_s        = 1'b0;
        mark_full_s    = 1'b0;
        release_fill_s = 1'b0;
        overrun_s      = 1'b0;
        abort_s        = 1'b0;
        we_s           = 2'b00;
        if (sync_i) begin
            wr_cnt_nxt_s = wr_cnt_r + CNT_ONE;
            if (wr_cnt_r == CNT_ZERO) begin
                if (bank_st_r[0] == BANK_EMPTY) begin
                    wr_bank_nxt_s = 1'b0;
                    wr_drop_nxt_s = 1'b0;
                    claim_s       = 1'b1;
                    we_s[0]       = 1'b1;
                end else if (bank_st_r[1] == BANK_EMPTY) begin
                    wr_bank_nxt_s = 1'b1;
                    wr_drop_nxt_s = 1'b0;
                    claim_s       = 1'b1;
                    we_s[1]       = 1'b1;
                end else begin
                    // No free bank: count the frame through without storing it.
                    wr_drop_nxt_s = 1'b1;
                    overrun_s     = 1'b1;
                end
            end else if (!wr_drop_r) begin
                we_s[wr_bank_r] = 1'b1;
                mark_full_s     = (wr_cnt_r == CNT_LAST);
            end else begin
                we_s = 2'b00;
            end
        end else begin
            if (wr_cnt_r != CNT_ZERO) begin
                // Upstream valid fell mid-frame; a dropped frame ends silently.
                wr_cnt_nxt_s   = CNT_ZERO;
                release_fill_s = !wr_drop_r;
                abort_s        = !wr_drop_r;
            end else begin
                wr_cnt_nxt_s = CNT_ZERO;
            end
        end
    end

    // Reader decisions: pick the oldest FULL bank when idle, and advance the
    // read address only when the output register can accept new data.
    always_comb begin
        pick_s       = pick_full_bank(bank_st_r[0], bank_st_r[1], oldest_r);
        full_found_s = pick_s[1];
        full_sel_s   = pick_s[0];
        cur_bank_s   = rd_active_r ? rd_bank_r : full_sel_s;
        room_s       = !valid_o_r || ready_i;
        issue_s      = room_s && (rd_active_r || full_found_s);
        rd_start_s   = issue_s && !rd_active_r;
        rd_done_s    = issue_s && rd_active_r && (rd_addr_r == CNT_LAST);
        re_s         = 2'b00;
        if (issue_s) begin
            re_s[cur_bank_s] = 1'b1;
        end else begin
            re_s = 2'b00;
        end
    end

    // Next bank states; writer and reader never act on the same bank in one
    // cycle, so both sets of transitions apply independently.
    always_comb begin
        bank_nxt_s[0] = bank_st_r[0];
        bank_nxt_s[1] = bank_st_r[1];
        oldest_nxt_s  = oldest_r;
        if (claim_s) begin
            bank_nxt_s[wr_bank_nxt_s] = BANK_FILLING;
        end else if (mark_full_s) begin
            bank_nxt_s[wr_bank_r] = BANK_FULL;
        end else if (release_fill_s) begin
            bank_nxt_s[wr_bank_r] = BANK_EMPTY;
        end else begin
            // no writer-side transition this cycle
        end
        if (mark_full_s && (bank_st_r[wr_other_s] != BANK_FULL)) begin
            oldest_nxt_s = wr_bank_r;
        end else begin
            oldest_nxt_s = oldest_r;
        end
        if (rd_done_s) begin
            bank_nxt_s[rd_bank_r] = BANK_EMPTY;
        end else if (rd_start_s) begin
            bank_nxt_s[full_sel_s] = BANK_READING;
        end else begin
            // no reader-side transition this cycle
        end
    end

    // Bank state and writer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bank_st_r[0] <= BANK_EMPTY;
            bank_st_r[1] <= BANK_EMPTY;
            oldest_r     <= 1'b0;
            wr_cnt_r     <= CNT_ZERO;
            wr_bank_r    <= 1'b0;
            wr_drop_r    <= 1'b0;
            overrun_o_r  <= 1'b0;
            abort_o_r    <= 1'b0;
        end else begin
            bank_st_r[0] <= bank_nxt_s[0];
            bank_st_r[1] <= bank_nxt_s[1];
            oldest_r     <= oldest_nxt_s;
            wr_cnt_r     <= wr_cnt_nxt_s;
            wr_bank_r    <= wr_bank_nxt_s;
            wr_drop_r    <= wr_drop_nxt_s;
            overrun_o_r  <= overrun_s;
            abort_o_r    <= abort_s;
        end
    end

    // Reader address counter and the RAM-read stage tag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_active_r <= 1'b0;
            rd_bank_r   <= 1'b0;
            rd_addr_r   <= CNT_ZERO;
            s1_vld_r    <= 1'b0;
            s1_bank_r   <= 1'b0;
            s1_addr_r   <= CNT_ZERO;
        end else begin
            if (issue_s) begin
                rd_addr_r <= rd_addr_r + CNT_ONE;
            end
            if (rd_done_s) begin
                rd_active_r <= 1'b0;
            end else if (rd_start_s) begin
                rd_active_r <= 1'b1;
                rd_bank_r   <= full_sel_s;
            end
            if (room_s) begin
                s1_vld_r <= issue_s;
                if (issue_s) begin
                    s1_bank_r <= cur_bank_s;
                    s1_addr_r <= rd_addr_r;
                end
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_reorder_ram #(
            .DEPTH (N),
            .AW    (N_LOG2),
            .WIDTH (2 * DW)
        ) u_ram (
            .clk_i   (clk_i),
            .we_i    (we_s[b]),
            .waddr_i (ctr_i),
            .wdata_i (wdata_s),
            .re_i    (re_s[b]),
            .raddr_i (rd_addr_r),
            .rdata_o (rdata_s[b])
        );
    end

    assign s1_data_s = s1_bank_r ? rdata_s[1] : rdata_s[0];

    // Output register: loads from the RAM-read stage whenever it has room,
    // otherwise holds the presented sample stable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o_r   <= 1'b0;
            ctr_o_r     <= CNT_ZERO;
            data_re_o_r <= {DW{1'b0}};
            data_im_o_r <= {DW{1'b0}};
            last_o_r    <= 1'b0;
        end else if (room_s) begin
            valid_o_r <= s1_vld_r;
            last_o_r  <= s1_vld_r && (s1_addr_r == CNT_LAST);
            if (s1_vld_r) begin
                ctr_o_r     <= s1_addr_r;
                data_re_o_r <= s1_data_s[2*DW-1:DW];
                data_im_o_r <= s1_data_s[DW-1:0];
            end
        end
    end

    assign valid_o   = valid_o_r;
    assign ctr_o     = ctr_o_r;
    assign data_re_o = data_re_o_r;
    assign data_im_o = data_im_o_r;
    assign last_o    = last_o_r;
    assign overrun_o = overrun_o_r;
    assign abort_o   = abort_o_r;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder at N=16, DW=8.
module tb_fft_bitrev_reorder;

    localparam int N  = 16;
    localparam int NL = 4;
    localparam int DW = 8;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 sync_i;
    logic [NL-1:0]        ctr_i;
    logic signed [DW-1:0] data_re_i;
    logic signed [DW-1:0] data_im_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [NL-1:0]        ctr_o;
    logic signed [DW-1:0] data_re_o;
    logic signed [DW-1:0] data_im_o;
    logic                 last_o;
    logic                 overrun_o;
    logic                 abort_o;

    always #5 clk_i = ~clk_i;

    fft_bitrev_reorder #(.N(N), .N_LOG2(NL), .DW(DW)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sync_i    (sync_i),
        .ctr_i     (ctr_i),
        .data_re_i (data_re_i),
        .data_im_i (data_im_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .ctr_o     (ctr_o),
        .data_re_o (data_re_o),
        .data_im_o (data_im_o),
        .last_o    (last_o),
        .overrun_o (overrun_o),
        .abort_o   (abort_o)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int last_drv_cyc = 0;

    int q_ctr[$];
    int q_re[$];
    int q_im[$];
    int q_last[$];
    int rise_cyc[$];
    int n_valid = 0;
    int n_stall = 0;
    int n_ovr = 0;
    int n_abt = 0;
    int hold_viol = 0;
    logic                 p_valid = 1'b0;
    logic                 p_ready = 1'b0;
    logic [NL-1:0]        p_ctr;
    logic signed [DW-1:0] p_re;
    logic signed [DW-1:0] p_im;
    logic                 p_last;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (valid_o === 1'b1) begin
            n_valid++;
            if (p_valid !== 1'b1) rise_cyc.push_back(cyc);
            if (ready_i) begin
                q_ctr.push_back(int'(ctr_o));
                q_re.push_back(int'(data_re_o));
                q_im.push_back(int'(data_im_o));
                q_last.push_back(int'(last_o));
            end else begin
                n_stall++;
            end
        end
        if (p_valid === 1'b1 && p_ready === 1'b0) begin
            if (!(valid_o === 1'b1 && ctr_o === p_ctr && data_re_o === p_re &&
                  data_im_o === p_im && last_o === p_last)) hold_viol++;
        end
        if (overrun_o === 1'b1) n_ovr++;
        if (abort_o === 1'b1) n_abt++;
        p_valid = valid_o;
        p_ready = ready_i;
        p_ctr   = ctr_o;
        p_re    = data_re_o;
        p_im    = data_im_o;
        p_last  = last_o;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int brev(input int x);
        int r;
        r = 0;
        for (int b = 0; b < NL; b++) begin
            if (x[b]) r = r | (1 << (NL - 1 - b));
        end
        return r;
    endfunction

    // Drive nsamp samples in bit-reversed bin order; sample value = bin + N*frame tag.
    task automatic drive(input int nsamp, input int tag0, input int lo_start, input int lo_len, input bit tail);
        int k;
        int v;
        for (int i = 0; i < nsamp; i++) begin
            @(posedge clk_i); #1;
            k = brev(i % N);
            v = k + N * (tag0 + i / N);
            sync_i    = 1'b1;
            ctr_i     = NL'(k);
            data_re_i = DW'(v);
            data_im_i = DW'(-v);
            ready_i   = !(i >= lo_start && i < lo_start + lo_len);
            last_drv_cyc = cyc;
        end
        if (tail) begin
            @(posedge clk_i); #1;
            sync_i  = 1'b0;
            ready_i = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check_frame(input int base, input int tag);
        int idx;
        int v;
        for (int k = 0; k < N; k++) begin
            idx = base + k;
            v = k + N * tag;
            if (idx < q_ctr.size()) begin
                chk($sformatf("f%0d_ctr%0d", tag, k), q_ctr[idx], k);
                chk($sformatf("f%0d_re%0d", tag, k), q_re[idx], v);
                chk($sformatf("f%0d_im%0d", tag, k), q_im[idx], -v);
                chk($sformatf("f%0d_last%0d", tag, k), q_last[idx], (k == N - 1) ? 1 : 0);
            end else begin
                chk($sformatf("f%0d_missing%0d", tag, k), q_ctr.size(), idx + 1);
            end
        end
    endtask

    initial begin
        int b;
        int r;
        int o;
        int a;
        int v;
        int s;
        int h;
        rst_i = 1'b1; sync_i = 1'b0; ready_i = 1'b1;
        ctr_i = '0; data_re_i = '0; data_im_i = '0;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_valid", valid_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_abort", abort_o, 0);
        chk("rst_ctr", ctr_o, 0);
        chk("rst_re", data_re_o, 0);
        chk("rst_im", data_im_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        idle(2);

        // Single frame: order, data, last, latency
        b = q_ctr.size(); r = rise_cyc.size(); o = n_ovr;
        drive(16, 0, -1, 0, 1'b1);
        idle(30);
        chk("a_count", q_ctr.size() - b, 16);
        if (rise_cyc.size() > r) chk("a_latency", rise_cyc[r] - last_drv_cyc, 3);
        else chk("a_latency_norise", rise_cyc.size(), r + 1);
        check_frame(b, 0);
        chk("a_overrun", n_ovr - o, 0);

        // Five back-to-back frames at full rate
        b = q_ctr.size(); r = rise_cyc.size(); o = n_ovr; v = n_valid;
        drive(80, 0, -1, 0, 1'b1);
        idle(40);
        chk("b_count", q_ctr.size() - b, 80);
        chk("b_valid_cycles", n_valid - v, 80);
        chk("b_runs", rise_cyc.size() - r, 1);
        chk("b_overrun", n_ovr - o, 0);
        for (int t = 0; t < 5; t++) check_frame(b + 16 * t, t);

        // Backpressure: 20 stalled cycles from mid frame 2, frame 3 dropped
        b = q_ctr.size(); o = n_ovr; a = n_abt; s = n_stall; h = hold_viol;
        drive(48, 1, 24, 20, 1'b1);
        idle(60);
        chk("c_count", q_ctr.size() - b, 32);
        chk("c_overrun", n_ovr - o, 1);
        chk("c_abort", n_abt - a, 0);
        chk("c_stall_cycles", n_stall - s, 20);
        chk("c_hold", hold_viol - h, 0);
        check_frame(b, 1);
        check_frame(b + 16, 2);

        // Partial frame aborted, then a clean frame
        b = q_ctr.size(); a = n_abt; o = n_ovr;
        drive(7, 0, -1, 0, 1'b1);
        idle(30);
        chk("d_abort", n_abt - a, 1);
        chk("d_count", q_ctr.size() - b, 0);
        b = q_ctr.size();
        drive(16, 3, -1, 0, 1'b1);
        idle(30);
        chk("d_count2", q_ctr.size() - b, 16);
        check_frame(b, 3);
        chk("d_abort2", n_abt - a, 1);
        chk("d_overrun", n_ovr - o, 0);

        // Reset during frame-0 output and frame-1 input
        drive(16, 1, -1, 0, 1'b1);
        drive(6, 2, -1, 0, 1'b0);
        #3;
        chk("e_pre_valid", valid_o, 1);
        rst_i  = 1'b1;
        sync_i = 1'b0;
        #1;
        chk("e_async_valid", valid_o, 0);
        chk("e_async_ctr", ctr_o, 0);
        chk("e_async_re", data_re_o, 0);
        chk("e_async_last", last_o, 0);
        b = q_ctr.size(); a = n_abt;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(40);
        chk("e_stale", q_ctr.size() - b, 0);
        chk("e_abort", n_abt - a, 0);
        b = q_ctr.size();
        drive(16, 4, -1, 0, 1'b1);
        idle(30);
        chk("e_count", q_ctr.size() - b, 16);
        check_frame(b, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
